// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch front end.
//   - PC_STEP        : byte distance between consecutive instruction words
//   - pc_align()     : clears the two low address bits (word alignment)
//   - fetch_entry_t  : queue record {pc, pc_next, inst} at the default widths
//   Modules with non-default widths build the same record shape locally from
//   their own parameters.
package fetch_pkg;

  localparam int PC_STEP        = 4;
  localparam int MAX_ADDR_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INST_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_ADDR_WIDTH-1:0] pc_next;
    logic [DEF_INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Works on the widest supported address; callers zero-extend in and
  // truncate back out, so one function serves every ADDR_WIDTH.
  function automatic logic [MAX_ADDR_WIDTH-1:0] pc_align(input logic [MAX_ADDR_WIDTH-1:0] addr);
    return {addr[MAX_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// fetch_fifo_mem
//   DEPTH x WIDTH register array backing the prefetch queue.
//   Ports:
//     clk   - rising-edge clock
//     we    - write enable
//     waddr - write address (queue write pointer)
//     wdata - entry to store
//     raddr - read address (queue read pointer)
//     rdata - entry at raddr, combinational read
//   Contents are never reset or cleared; validity is tracked by the owner.
module fetch_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain storage: one write per cycle, no reset, because the queue
  // pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read so the head entry is visible to ID the cycle after
  // it was written, with no extra register stage.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   PC generator plus DEPTH-entry prefetch queue between instruction memory
//   and the ID pipeline register.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     inst_ren / inst_addr     - fetch request and address (current PC)
//     inst_ack / inst_data     - memory accept and same-cycle data
//     redirect_en/redirect_pc  - branch/jump: flush queue, load new PC
//     id_valid / id_ready      - head-of-queue handshake with ID
//     id_inst/id_pc/id_pc_next - head entry contents
//     count                    - current occupancy
module fetch_queue import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_ren,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_ack,
  input  logic [INST_WIDTH-1:0] inst_data,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_next,
  output logic [CNT_W-1:0]      count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  entry_t                wr_entry;
  entry_t                rd_entry;

  // PC arithmetic wraps naturally at 2^ADDR_WIDTH.
  assign pc_plus          = pc + ADDR_WIDTH'(PC_STEP);
  assign redirect_aligned = ADDR_WIDTH'(pc_align(MAX_ADDR_WIDTH'(redirect_pc)));

  // A redirect suppresses both handshakes in its own cycle. A full queue
  // still requests when ID is popping, so a full queue streams at one word
  // per cycle.
  assign id_valid  = (count != '0) && !redirect_en;
  assign pop       = id_valid && id_ready;
  assign inst_ren  = !redirect_en && ((count < CNT_W'(DEPTH)) || pop);
  assign push      = inst_ren && inst_ack;
  assign inst_addr = pc;

  assign wr_entry = '{pc: pc, pc_next: pc_plus, inst: inst_data};

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign id_inst    = rd_entry.inst;
  assign id_pc      = rd_entry.pc;
  assign id_pc_next = rd_entry.pc_next;

  // Pointer, occupancy and PC state. Redirect wins over everything else and
  // restarts the queue from slot 0 at the aligned target. Otherwise pushes
  // advance the write pointer and the PC, pops advance the read pointer, and
  // count only moves when exactly one of the two happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_en) begin
      pc     <= redirect_aligned;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc_plus;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
